// File: rtl/pipe_reg_stage.sv
// Two-entry skid-buffer pipeline register with bubble insertion and flush; optional stall counter under PIPE_STALL_CNT_EN.
// Latency: one cycle from input acceptance to valid_o when the main register is empty.
// Backpressure: ready_o drops only when both entries are held, so the upstream ready has no combinational path from ready_i.
module pipe_reg_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        occupancy_o
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    assign ready_o     = (state_q != FULL) && !rst_i;
    assign valid_o     = (state_q != EMPTY);
    assign in_xfer     = valid_i && ready_o;
    assign out_xfer    = valid_o && ready_i;
    assign occupancy_o = state_q;
    assign data_o      = main_data_q;
    // Control bits are forced to a bubble whenever nothing is presented.
    assign ctrl_o      = valid_o ? main_ctrl_q : '0;

    // Next-state and register-load decisions; flush empties the stage and drops any input.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register; reset overrides flush and every transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers; main keeps its last value when the stage drains so data_o stays put.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (load_main_in) begin
                main_data_q <= data_i;
                main_ctrl_q <= ctrl_i;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (load_skid) begin
                skid_data_q <= data_i;
                skid_ctrl_q <= ctrl_i;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturating count of cycles the downstream refused a presented entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && !flush_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pipe_reg_stage.md
PIPE_REG_STAGE -- requirements
Module: pipe_reg_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of the datapath payload (operands, immediates, addresses).
REQ-002 Parameter CTRL_W, default 8: width of the control payload (WB/MEM/EX-type bits), zeroed on bubble or flush.
REQ-003 Parameter CNT_W, default 16: width of the stall counter.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 flush_i  in  1  discards all held entries.
REQ-008 valid_i  in  1  upstream has an entry.
REQ-009 ready_o  out  1  stage can accept an entry.
REQ-010 data_i  in  DATA_W  upstream data payload.
REQ-011 ctrl_i  in  CTRL_W  upstream control payload.
REQ-012 valid_o  out  1  output entry present.
REQ-013 ready_i  in  1  downstream accepts the output entry.
REQ-014 data_o  out  DATA_W  output data payload.
REQ-015 ctrl_o  out  CTRL_W  output control payload.
REQ-016 occupancy_o  out  2  held entries, 0..2.
REQ-017 stall_cnt_o  out  CNT_W  downstream-stall cycle count; present only under PIPE_STALL_CNT_EN.

Function
REQ-018 The block SHALL be a two-entry skid buffer: a main register drives the outputs and a skid register sits behind it.
REQ-019 An input transfer SHALL occur when valid_i && ready_o; an output transfer SHALL occur when valid_o && ready_i.
REQ-020 ready_o SHALL equal (occupancy_o != 2) && !rst_i; no other input-to-output combinational path.
REQ-021 Latency: an entry accepted at edge N SHALL appear on valid_o/data_o/ctrl_o in the cycle after edge N when the main register is empty.
REQ-022 States EMPTY(0), ONE(1), FULL(2), with these transitions:
- EMPTY: input transfer -> ONE.
- ONE: in&&!out -> FULL (new entry to skid); in&&out -> ONE (new entry to main); !in&&out -> EMPTY; else hold.
- FULL: out -> ONE (skid moves to main); else hold.
REQ-023 Entries SHALL leave in acceptance order; none lost or duplicated.
REQ-024 Downstream stall (valid_o && !ready_i) SHALL hold data_o and ctrl_o stable.
REQ-025 When valid_o=0, ctrl_o SHALL be all-zero (bubble) and data_o SHALL hold its last value.
REQ-026 flush_i=1 at an edge SHALL force EMPTY, drop any input transfer in that cycle, and zero ctrl_o.
REQ-027 If flush_i and ready_i are both 1 in a cycle, the output transfer SHALL count as completed.

Reset
REQ-028 When rst_i=1 at an edge, the block SHALL reset to EMPTY: valid_o=0, occupancy_o=0, data_o=0, ctrl_o=0, skid cleared, stall_cnt_o=0.
REQ-029 Reset SHALL take priority over flush_i and all transfers.
REQ-030 Reset asserted mid-stall or while FULL SHALL discard both entries.
REQ-031 ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Configuration
REQ-032 With macro PIPE_STALL_CNT_EN defined:
- stall_cnt_o SHALL increment by 1 each cycle valid_o && !ready_i && !flush_i.
- It SHALL saturate at 2^CNT_W-1 and clear only on reset.
REQ-033 Without PIPE_STALL_CNT_EN, the stall_cnt_o port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Streaming: ready_i=1, valid_i=1 for 8 cycles, data_i=0..7 -> data_o=0..7 with valid_o on consecutive cycles, 1-cycle latency, ready_o always 1.
REQ-035 Backpressure: ready_i=0, push A5 then B6 -> occupancy_o=2, ready_o=0, data_o=A5 stable; then ready_i=1 -> A5, then B6 out, occupancy_o returns to 0.
REQ-036 Bubble: valid_i=0 after one entry with ctrl_i=8'hFF -> ctrl_o=8'hFF for one cycle, then ctrl_o=0 and valid_o=0.
REQ-037 Flush: FULL with ready_i=0, assert flush_i with valid_i=1 -> next cycle occupancy_o=0, valid_o=0, ctrl_o=0, input dropped.
REQ-038 Reset mid-operation: FULL, rst_i=1 one cycle -> all outputs 0, ready_o=1 after deassert; with PIPE_STALL_CNT_EN and CNT_W=4, 20 stall cycles -> stall_cnt_o=15.
